// File: rtl/div_unit.sv
// div_unit: 32-bit iterative restoring divider with RV32M DIV/DIVU/REM/REMU
// semantics. Fixed latency: accept, 32 CALC steps, one FIX step, one DONE cycle.
module div_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] r_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;     // partial remainder
  logic [31:0] quo_q, quo_d;     // dividend shifting out / quotient shifting in
  logic [31:0] dvs_q, dvs_d;     // magnitude of the divisor
  logic [31:0] a_q, a_d;         // raw dividend, needed for REM by zero
  logic [1:0]  op_q, op_d;
  logic        neg_q, neg_d;     // negate the selected result in FIX
  logic        dz_q, dz_d;       // divide by zero
  logic        ovf_q, ovf_d;     // signed overflow
  logic [31:0] r_q, r_d;

  logic        accept_s;
  logic        signed_op_s;
  logic [31:0] abs_a_s, abs_b_s;
  logic [32:0] shifted_s, diff_s;
  logic [31:0] res_s, fixed_s;

  assign busy_o = (state_q == CALC) || (state_q == FIX);
  assign done_o = (state_q == DONE);
  assign r_o    = r_q;

  // Operand preparation, one restoring step and sign/special-case correction.
  always_comb begin
    accept_s    = start_i && ((state_q == IDLE) || (state_q == DONE));
    signed_op_s = ~op_i[0];
    if (signed_op_s && a_i[31]) begin
      abs_a_s = 32'd0 - a_i;
    end else begin
      abs_a_s = a_i;
    end
    if (signed_op_s && b_i[31]) begin
      abs_b_s = 32'd0 - b_i;
    end else begin
      abs_b_s = b_i;
    end
    // A 33-bit subtract: bit 32 set means the trial went negative (borrow).
    shifted_s = {rem_q, quo_q[31]};
    diff_s    = shifted_s - {1'b0, dvs_q};
    if (op_q[1]) begin
      res_s = rem_q;
    end else begin
      res_s = quo_q;
    end
    if (dz_q) begin
      fixed_s = op_q[1] ? a_q : 32'hFFFF_FFFF;
    end else if (ovf_q) begin
      fixed_s = op_q[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else if (neg_q) begin
      fixed_s = 32'd0 - res_s;
    end else begin
      fixed_s = res_s;
    end
  end

  // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    op_d    = op_q;
    neg_d   = neg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    r_d     = r_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept_s) begin
          state_d = CALC;
          cnt_d   = 5'd0;
          rem_d   = 32'd0;
          quo_d   = abs_a_s;
          dvs_d   = abs_b_s;
          a_d     = a_i;
          op_d    = op_i;
          neg_d   = signed_op_s && (op_i[1] ? a_i[31] : (a_i[31] ^ b_i[31]));
          dz_d    = (b_i == 32'd0);
          ovf_d   = signed_op_s && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (!diff_s[32]) begin
          rem_d = diff_s[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted_s[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      FIX: begin
        r_d     = fixed_s;
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset taking priority over start_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      a_q     <= 32'd0;
      op_q    <= 2'd0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      r_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      r_q     <= r_d;
    end
  end

endmodule
